// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// Round-robin arbiter and break-before-make sequencer for a tri-state bus of N bufz drivers.
// Define GF180MCU_FD_SC_MCU7T5V0_BUFZ_ARB_PARK_EN to park the last owner's EN while idle.
module gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(
  parameter int N       = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [N-1:0]         EN,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 BUSY,
  inout  wire                  VDD,
  inout  wire                  VSS
);
  // state   | meaning
  // S_IDLE  | no owner; EN low, or parked on the last owner
  // S_DRIVE | OWNER holds the bus, EN = GNT
  // S_TURN  | break-before-make dead cycles, all EN low

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int TW = $clog2(TURN + 1);
  localparam logic [HW-1:0] HC_SAT   = HW'(MAXHOLD);
  localparam logic [HW-1:0] HC_PRE   = HW'(MAXHOLD - 1);
  localparam logic [TW-1:0] TC_LOAD  = TW'(TURN - 1);
  localparam logic [PW:0]   N_W      = (PW+1)'(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
`ifdef GF180MCU_FD_SC_MCU7T5V0_BUFZ_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  state_t        state_q, state_nxt;
  logic [PW-1:0] ptr_q, ptr_nxt, owner_nxt, win;
  logic [HW-1:0] hc_q, hc_nxt;
  logic [TW-1:0] tc_q, tc_nxt;
  logic          park_q, park_nxt;
  logic [N-1:0]  own_mask, rot, gnt_nxt, en_nxt;
  logic [PW:0]   win_off, win_sum;
  logic          found, any_req, own_req, other_req, grant_go;
  wire           supply_unused;

  assign supply_unused = VDD ^ VSS;

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotate so bit 0 is the pointer position, find the first set bit, map back.
  always_comb begin
    rot     = N'({REQ, REQ} >> ptr_q);
    found   = 1'b0;
    win_off = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found   = 1'b1;
        win_off = (PW+1)'(i);
      end
    end
    win_sum = {1'b0, ptr_q} + win_off;
    if (win_sum >= N_W) win_sum = win_sum - N_W;
    win = win_sum[PW-1:0];
  end

  assign any_req   = |REQ;
  assign own_mask  = onehot(OWNER);
  assign own_req   = |(REQ & own_mask);
  assign other_req = |(REQ & ~own_mask);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      OWNER   <= '0;
      hc_q    <= '0;
      tc_q    <= '0;
      park_q  <= 1'b0;
      GNT     <= '0;
      EN      <= '0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      OWNER   <= owner_nxt;
      hc_q    <= hc_nxt;
      tc_q    <= tc_nxt;
      park_q  <= park_nxt;
      GNT     <= gnt_nxt;
      EN      <= en_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    owner_nxt = OWNER;
    hc_nxt    = hc_q;
    tc_nxt    = tc_q;
    park_nxt  = park_q;
    grant_go  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // A parked bus must go dead before a different driver may enable.
          if (PARK && park_q && (win != OWNER)) begin
            state_nxt = S_TURN;
            tc_nxt    = TC_LOAD;
            park_nxt  = 1'b0;
          end else begin
            grant_go = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (hc_q != HC_SAT) hc_nxt = hc_q + 1'b1;
        if (!own_req || (other_req && (hc_q >= HC_PRE))) begin
          if (other_req) begin
            state_nxt = S_TURN;
            tc_nxt    = TC_LOAD;
          end else begin
            state_nxt = S_IDLE;
            park_nxt  = PARK;
          end
        end
      end
      S_TURN: begin
        if (tc_q != '0) tc_nxt = tc_q - 1'b1;
        else if (any_req) grant_go = 1'b1;
        else state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (grant_go) begin
      state_nxt = S_DRIVE;
      owner_nxt = win;
      ptr_nxt   = (win == LAST_IDX) ? '0 : win + 1'b1;
      hc_nxt    = '0;
      park_nxt  = 1'b0;
    end
  end

  always_comb begin
    gnt_nxt = '0;
    en_nxt  = '0;
    if (state_nxt == S_DRIVE) begin
      gnt_nxt = onehot(owner_nxt);
      en_nxt  = gnt_nxt;
    end else if ((state_nxt == S_IDLE) && park_nxt) begin
      en_nxt = onehot(owner_nxt);
    end
  end

  assign BUSY = (state_q != S_IDLE);

  a_en_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(EN));
  a_break_before_make: assert property (@(posedge CLK) disable iff (RST)
    ((EN != '0) && ($past(EN) != '0)) |-> (EN == $past(EN)));

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// Bench for the bufz bus arbiter: ownership-level model checked every cycle plus directed literals.
module tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb;
  localparam int NR = 4;
  localparam int TURN = 1;
  localparam int MAXHOLD = 16;
`ifdef GF180MCU_FD_SC_MCU7T5V0_BUFZ_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif
  localparam logic [3:0] DROP_EN = PARK ? 4'b0001 : 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, en, prev_en;
  logic [1:0] owner;
  logic       busy;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(.N(NR), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt), .EN(en),
    .OWNER(owner), .BUSY(busy), .VDD(vdd), .VSS(vss)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, cycles owned so far, dead cycles left, rotation start, parked driver.
  typedef struct {
    int cur;
    int gap;
    int held;
    int ptr;
    int last;
    int park;
  } mdl_t;

  mdl_t m = '{-1, 0, 0, 0, 0, -1};

  function automatic int pick(input logic [3:0] r, input int p);
    int j;
    pick = -1;
    for (int i = 0; i < NR; i++) begin
      j = (p + i) % NR;
      if (pick < 0 && r[j]) pick = j;
    end
  endfunction

  function automatic mdl_t give(input mdl_t s, input int w);
    mdl_t t = s;
    t.cur = w; t.ptr = (w + 1) % NR; t.held = 0; t.last = w; t.park = -1;
    return t;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic [3:0] r);
    mdl_t t = s;
    int w;
    bit oth;
    if (s.cur >= 0) begin
      t.held = s.held + 1;
      oth = (r & ~(4'(1) << s.cur)) != 4'b0000;
      if (!r[s.cur] || (oth && t.held >= MAXHOLD)) begin
        if (oth) t.gap = TURN;
        else if (PARK) t.park = s.cur;
        t.cur = -1;
      end
    end else if (s.gap > 0) begin
      t.gap = s.gap - 1;
      if (t.gap == 0) begin
        w = pick(r, s.ptr);
        if (w >= 0) t = give(t, w);
      end
    end else begin
      w = pick(r, s.ptr);
      if (w >= 0) begin
        if (s.park >= 0 && w != s.park) begin
          t.gap = TURN;
          t.park = -1;
        end else begin
          t = give(t, w);
        end
      end
    end
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{-1, 0, 0, 0, 0, -1};
    else m <= step(m, req);
  end

  logic [3:0] exp_gnt, exp_en;
  always @(negedge clk) begin
    exp_gnt = (m.cur >= 0) ? (4'(1) << m.cur) : 4'b0000;
    exp_en  = exp_gnt | ((m.park >= 0) ? (4'(1) << m.park) : 4'b0000);
    check("model_gnt", 32'(gnt), 32'(exp_gnt));
    check("model_en", 32'(en), 32'(exp_en));
    check("model_owner", 32'(owner), m.last);
    check("model_busy", 32'(busy), 32'(m.cur >= 0 || m.gap > 0));
    check("break_before_make", 32'(prev_en != 0 && en != 0 && en != prev_en), 0);
    prev_en <= en;
  end

  task automatic apply_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] pat [8] = '{4'b0110, 4'b0110, 4'b1001, 4'b0000, 4'b1111, 4'b0101, 4'b0011, 4'b0000};
  logic [3:0] rr_exp;
  int cnt;

  initial begin
    prev_en = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_gnt", 32'(gnt), 0);
    check("reset_en", 32'(en), 0);
    check("reset_owner", 32'(owner), 0);
    check("reset_busy", 32'(busy), 0);

    // single request
    req = 4'b0001; @(negedge clk);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_en", 32'(en), 32'h1);
    check("single_owner", 32'(owner), 0);
    check("single_busy", 32'(busy), 1);
    repeat (3) @(negedge clk);
    req = 4'b0000; @(negedge clk);
    check("drop_en", 32'(en), 32'(DROP_EN));
    check("drop_busy", 32'(busy), 0);

    // handover 0 -> 2
    req = 4'b0001; @(negedge clk);
    check("ho_first_en", 32'(en), 32'h1);
    req = 4'b0100; @(negedge clk);
    check("ho_dead_en", 32'(en), 0);
    check("ho_dead_busy", 32'(busy), 1);
    @(negedge clk);
    check("ho_new_en", 32'(en), 32'h4);
    check("ho_new_owner", 32'(owner), 2);
    req = 4'b0000; repeat (2) @(negedge clk);

    // contention arriving after a long solo hold preempts at once
    apply_reset();
    req = 4'b0001; repeat (20) @(negedge clk);
    req = 4'b0011; @(negedge clk);
    check("late_pre_dead", 32'(en), 0);
    @(negedge clk);
    check("late_pre_en", 32'(en), 32'h2);
    req = 4'b0000; repeat (2) @(negedge clk);

    // round robin with preemption
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rr_exp = 4'(1) << (k % NR);
      cnt = 0;
      repeat (MAXHOLD) begin
        @(negedge clk);
        if (en == rr_exp) cnt++;
      end
      check($sformatf("rr_hold_%0d", k), cnt, MAXHOLD);
      @(negedge clk);
      check($sformatf("rr_dead_%0d", k), 32'(en), 0);
    end
    req = 4'b0000; repeat (2) @(negedge clk);

    // async reset mid-drive
    apply_reset();
    req = 4'b0001; repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_en", 32'(en), 0);
    check("async_gnt", 32'(gnt), 0);
    req = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_en", 32'(en), 32'h2);
    check("post_rst_owner", 32'(owner), 1);
    req = 4'b0000; repeat (2) @(negedge clk);

    // request withdrawn before the turnaround ends
    apply_reset();
    req = 4'b0001; @(negedge clk);
    req = 4'b1000; @(negedge clk);
    check("wd_turn_en", 32'(en), 0);
    check("wd_turn_busy", 32'(busy), 1);
    req = 4'b0000; @(negedge clk);
    check("wd_idle_en", 32'(en), 0);
    check("wd_idle_gnt", 32'(gnt), 0);
    check("wd_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("wd_still_en", 32'(en), 0);

    // mixed patterns, checked by the model
    foreach (pat[i]) begin
      req = pat[i];
      repeat (5) @(negedge clk);
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0_BUFZ_ARB_PARK_EN
    apply_reset();
    req = 4'b0010; @(negedge clk);
    check("park_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000; @(negedge clk);
    check("park_en", 32'(en), 32'h2);
    check("park_gnt0", 32'(gnt), 0);
    req = 4'b0010; @(negedge clk);
    check("park_regrant", 32'(gnt), 32'h2);
    req = 4'b0000; @(negedge clk);
    req = 4'b0100; @(negedge clk);
    check("park_dead_en", 32'(en), 0);
    @(negedge clk);
    check("park_new_en", 32'(en), 32'h4);
    check("park_new_owner", 32'(owner), 2);
    req = 4'b0000; repeat (2) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
